program_counter_control: RTL
============================

// Module: program_counter_control
// PURPOSE
//   Program-counter sequencer feeding instruction fetch. Directly consumes the jump_immediate/branch
//   decision made for the instruction in execute, plus call/return markers from decode.
//   Redirects fetch, flushes the fetch pipe, maintains a hardware call-return stack and counts
//   taken conditional branches.
// PARAMETERS
//   WORD_WIDTH          32  width of data word (taken-branch counter width)
//   PROGRAM_ADDR_WIDTH  32  width of program addresses
//   CALL_DEPTH           8  return-stack entries (power of 2, >=2)
// PORTS
//   clk              in   1       sole clock, rising edge
//   reset_n          in   1       synchronous, active-low reset
//   exec_valid       in   1       execute-stage instruction valid this cycle; all exec_* inputs qualified by it
//   exec_pc          in   PAW     address of instruction in execute
//   jump_immediate   in   1       redirect to jump_target (already resolved condition)
//   branch           in   1       instruction is a conditional branch
//   call             in   1       instruction is CALLI (push return address)
//   ret              in   1       instruction is a return (pop return address and redirect)
//   jump_target      in   PAW     immediate target address
//   imem_ready       in   1       instruction memory accepts imem_addr this cycle
//   imem_req         out  1       fetch request valid
//   imem_addr        out  PAW     fetch address
//   flush            out  1       one-cycle pulse: discard fetched/decoded instructions younger than exec
//   call_overflow    out  1       sticky: call with stack full
//   call_underflow   out  1       sticky: ret with stack empty
//   taken_branches   out  WORD_WIDTH  count of taken conditional branches, saturating
// BEHAVIOUR
//   Reset (reset_n=0 at clk edge): state=BOOT, imem_addr=0, imem_req=0, flush=0, stack empty,
//     call_overflow=0, call_underflow=0, taken_branches=0. Reset overrides everything mid-operation.
//   FSM: BOOT -> RUN (next cycle, imem_req=1 from then). RUN -> FAULT on overflow/underflow.
//     FAULT: imem_req=0, flush=0, nothing changes; exit only via reset.
//   RUN fetch: handshake completes when imem_req & imem_ready; then imem_addr <= imem_addr+1
//     (wraps modulo 2^PAW). While imem_req & ~imem_ready, imem_addr held stable unless redirected.
//   Redirect (RUN, exec_valid=1), priority high->low:
//     1. jump_immediate=1: imem_addr <= jump_target; flush=1 next cycle. If call=1 also push exec_pc+1
//        (wraps). If branch=1, taken_branches++ (saturates at all-ones).
//     2. ret=1 (jump_immediate=0): imem_addr <= top of stack; pop; flush=1 next cycle.
//     3. otherwise: no redirect; call/ret ignored when jump_immediate=0 except as in 2.
//   Redirect overrides a pending unaccepted fetch (request dropped, new address presented);
//     a fetch accepted in the same cycle as a redirect is discarded via flush.
//   flush asserted exactly one cycle, the cycle after the redirecting exec_valid cycle.
//   Stack: depth CALL_DEPTH. Push when full -> no push, call_overflow=1, state FAULT next cycle,
//     no redirect. Pop when empty -> call_underflow=1, FAULT, no redirect.
//     Call with ret both asserted: call wins (jump_immediate=1 path), ret ignored.
//   Latency: decision to new imem_addr visible 1 cycle; no combinational path inputs->outputs.
//   exec_valid=0: all exec_* inputs ignored; counter/stack unchanged.
// TESTING
//   1. Reset release, imem_ready=1 -> imem_addr 0,1,2,3 on successive cycles from cycle 2; flush=0.
//   2. imem_ready=0 for 3 cycles at addr 5 -> imem_addr stays 5; then ready -> 6.
//   3. exec_pc=0x10, jump_immediate=1, call=1, target=0x100 -> imem_addr=0x100, flush 1 cycle;
//      later ret=1 -> imem_addr=0x11, stack empty again.
//   4. 8 nested calls then 9th call -> call_overflow=1, imem_req=0 held; reset_n=0 clears all.
//   5. ret with empty stack -> call_underflow=1, FAULT, imem_addr unchanged.
//   6. branch=1 jump_immediate=1 x3, branch=1 jump_immediate=0 x2 -> taken_branches=3; preload near
//      all-ones -> saturates; exec_valid=0 with jump_immediate=1 -> no redirect.

Source files
------------

// File: rtl/program_counter_control.sv
// Program-counter sequencer: drives instruction fetch, redirects on jumps/returns,
// keeps a hardware return stack and counts taken conditional branches.
module program_counter_control #(
    parameter int WORD_WIDTH         = 32,
    parameter int PROGRAM_ADDR_WIDTH = 32,
    parameter int CALL_DEPTH         = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          exec_valid,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] exec_pc,
    input  logic                          jump_immediate,
    input  logic                          branch,
    input  logic                          call,
    input  logic                          ret,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] jump_target,
    input  logic                          imem_ready,
    output logic                          imem_req,
    output logic [PROGRAM_ADDR_WIDTH-1:0] imem_addr,
    output logic                          flush,
    output logic                          call_overflow,
    output logic                          call_underflow,
    output logic [WORD_WIDTH-1:0]         taken_branches
);

    localparam int PAW  = PROGRAM_ADDR_WIDTH;
    localparam int IDXW = $clog2(CALL_DEPTH);
    localparam int SPW  = IDXW + 1;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t state;

    logic [PAW-1:0] stack_mem [CALL_DEPTH];
    logic [SPW-1:0] sp;
    logic           stack_full;
    logic           stack_empty;
    logic [PAW-1:0] stack_top;
    logic [PAW-1:0] return_addr;

    logic run_exec;
    logic take_jump;
    logic take_ret;
    logic push_overflow;
    logic pop_underflow;
    logic do_push;
    logic count_branch;

    assign stack_full  = (sp == SPW'(CALL_DEPTH));
    assign stack_empty = (sp == '0);
    assign stack_top   = stack_mem[IDXW'(sp - SPW'(1))];
    assign return_addr = exec_pc + PAW'(1);

    // Decisions for the instruction in execute; only meaningful while running.
    assign run_exec      = (state == RUN) && exec_valid;
    assign push_overflow = run_exec && jump_immediate && call && stack_full;
    assign take_jump     = run_exec && jump_immediate && !push_overflow;
    assign pop_underflow = run_exec && !jump_immediate && ret && stack_empty;
    assign take_ret      = run_exec && !jump_immediate && ret && !stack_empty;
    assign do_push       = take_jump && call;
    assign count_branch  = take_jump && branch && (taken_branches != '1);

    // Stack storage needs no reset: sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[sp[IDXW-1:0]] <= return_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= BOOT;
            imem_req       <= 1'b0;
            imem_addr      <= '0;
            flush          <= 1'b0;
            sp             <= '0;
            call_overflow  <= 1'b0;
            call_underflow <= 1'b0;
            taken_branches <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state    <= RUN;
                    imem_req <= 1'b1;
                    flush    <= 1'b0;
                end
                RUN: begin
                    flush <= 1'b0;
                    if (push_overflow) begin
                        call_overflow <= 1'b1;
                        imem_req      <= 1'b0;
                        state         <= FAULT;
                    end else if (pop_underflow) begin
                        call_underflow <= 1'b1;
                        imem_req       <= 1'b0;
                        state          <= FAULT;
                    end else if (take_jump) begin
                        // A fetch accepted this same cycle is wrong-path; flush discards it.
                        imem_addr <= jump_target;
                        flush     <= 1'b1;
                        if (call) begin
                            sp <= sp + SPW'(1);
                        end
                        if (count_branch) begin
                            taken_branches <= taken_branches + WORD_WIDTH'(1);
                        end
                    end else if (take_ret) begin
                        imem_addr <= stack_top;
                        sp        <= sp - SPW'(1);
                        flush     <= 1'b1;
                    end else if (imem_req && imem_ready) begin
                        imem_addr <= imem_addr + PAW'(1);
                    end
                end
                FAULT: begin
                    imem_req <= 1'b0;
                    flush    <= 1'b0;
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

endmodule
